input_vc_buffer: RTL and testbench
==================================

Name: input_vc_buffer

Overview:
- Receive end of the router-to-router link: accepts the flit stream (data, valid, virtual channel) driven by an upstream output-port mux.
- Stores each flit in a per-virtual-channel FIFO.
- Releases flits to the local crossbar on read requests and returns one credit upstream per flit popped.
- One instance sits at each of the 5 router input ports (4 hypercube dimensions + local).

Parameters:
- DATA_WIDTH, `DATA_WIDTH (defines.v): flit width.
- VCH_W, `VCH_WIDTH_NUM (defines.v): VC index width. VC_NUM = 2**VCH_W (4 by default).
- DEPTH, 4: entries per VC FIFO. Must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- idata  in  DATA_WIDTH  flit from link.
- ivalid  in  1  flit present this cycle.
- ivch  in  VCH_W  target VC of incoming flit.
- ird_en  in  1  crossbar read request.
- ird_vch  in  VCH_W  VC to pop.
- odata  out  DATA_WIDTH  popped flit (registered).
- ovalid  out  1  odata valid (registered).
- ovch  out  VCH_W  VC of popped flit (registered).
- ocredit_valid  out  1  credit return pulse to upstream (registered).
- ocredit_vch  out  VCH_W  VC the credit belongs to.
- ovc_nempty  out  VC_NUM  per-VC non-empty flags (combinational from counters).
- oerr  out  1  sticky protocol error (only with feature).

Behaviour:
- Reset (rst=1 at a rising edge):
  - All rd/wr pointers and counters go to 0.
  - odata=0, ovalid=0, ovch=0, ocredit_valid=0, ocredit_vch=0, oerr=0, ovc_nempty=0.
  - Reset mid-stream discards all stored flits. No credits are emitted for them; upstream is reset in the same cycle.
- Write:
  - When ivalid=1, idata is stored at FIFO[ivch].wr_ptr. The pointer increments modulo DEPTH and the count increments.
  - Write is accepted if count<DEPTH, or if the same VC is popped in the same cycle.
  - A write to a full FIFO with no concurrent pop is dropped: no state change.
- Read:
  - When ird_en=1 and count[ird_vch]>0, the head is popped; rd_ptr increments modulo DEPTH and the count decrements.
  - Next cycle: odata=head, ovalid=1, ovch=ird_vch, ocredit_valid=1, ocredit_vch=ird_vch. Latency is 1 cycle.
  - ird_en=1 on an empty VC: the next cycle has ovalid=0 and ocredit_valid=0. odata holds its previous value.
  - ird_en=0: the next cycle has ovalid=0 and ocredit_valid=0.
- Simultaneous write and read, same VC:
  - Non-empty: both occur and the count is unchanged.
  - Empty: the write occurs, the read sees empty and does not pop. There is no bypass; earliest read-out is 2 cycles after write.
  - Full: the pop frees a slot, the write is accepted, and the count stays at DEPTH.
- Simultaneous write and read, different VCs: fully independent.
- Pointer wrap is natural modulo DEPTH. Counters never exceed DEPTH and never go below 0.
- ovc_nempty[v] = (count[v]!=0); it reflects state after the last clock edge.
- Credit contract: upstream starts with DEPTH credits per VC. Exactly one credit pulse is emitted per successful pop. Total credits returned equals total flits popped.

Optional Feature:
- Macro INBUF_ERR_CHECK_EN.
- Defined: oerr is set and held until rst on either condition:
  - a write dropped at full (credit violation);
  - ird_en to an empty VC (allocator violation).
- Not defined: the oerr port still exists, tied to 0, with no detection logic. Data-path behaviour is identical in both cases.

Decomposition:
- Shared package/defines: `DATA_WIDTH, `VCH_WIDTH_NUM, `PORT, plus a new `VC_NUM constant and `INBUF_DEPTH default. Both the mux side and the buffer side use the same definitions.
- One sub-module, vc_fifo:
  - single-VC synchronous FIFO;
  - ports: clk, rst, wr_en, wr_data, rd_en, rd_data, count, full, empty;
  - instantiated VC_NUM times by a generate loop.
- The top level holds write/read demux decode, the output/credit registers and the error logic.

Test Plan:
- Reset, then ivalid=1 ivch=2 idata=0xA5, then ird_en=1 ird_vch=2 one cycle later -> ovc_nempty=4'b0100 after the write; next cycle odata=0xA5, ovalid=1, ovch=2, ocredit_valid=1, ocredit_vch=2.
- Write 4 flits 1,2,3,4 to VC0, then pop 4 times -> odata is 1,2,3,4 in order; 4 credit pulses on vch 0; ovc_nempty[0]=0 afterwards.
- Fill VC1 with 4 flits, then a 5th write (10) with no pop -> flit dropped; pops return only the first 4; oerr=1 with INBUF_ERR_CHECK_EN, 0 without.
- VC3 full; same cycle write 0x77 and pop -> head popped, count stays 4; 0x77 appears as the 4th subsequent pop.
- VC0 empty; write 0x11 and ird_en on VC0 in the same cycle -> next cycle ovalid=0, no credit; a pop the following cycle returns 0x11.
- Interleaved traffic: writes to VC0 and VC1 alternate every cycle while VC2 is popped -> per-VC order preserved; credits match pops exactly; assert rst mid-stream -> all counts 0 and outputs 0 on the next cycle.

Source files
------------

// File: rtl/input_vc_buffer_pkg.sv
// ============================================================================
// Module  : input_vc_buffer_pkg
// Purpose : Router-wide constants shared by the link output mux and the
//           input VC buffer, so both ends of a link agree on flit width,
//           VC count and buffer depth.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package input_vc_buffer_pkg;

  // Flit payload width carried on every router link.
  localparam int DATA_WIDTH_DEF = 16;

  // Width of the virtual-channel index carried alongside each flit.
  localparam int VCH_WIDTH_NUM = 2;

  // Number of virtual channels per link.
  localparam int VC_NUM_DEF = 2 ** VCH_WIDTH_NUM;

  // Router ports: 4 hypercube dimensions plus the local port.
  localparam int PORT_NUM = 5;

  // Default entries per VC FIFO (power of 2, at least 2). Upstream starts
  // with this many credits per VC.
  localparam int INBUF_DEPTH = 4;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : input_vc_buffer_pkg

`default_nettype wire

// File: rtl/input_vc_buffer_if.sv
// ============================================================================
// Module  : input_vc_buffer_if
// Purpose : Link-side and crossbar-side signal bundle of one input VC buffer.
//   Link in     : idata, ivalid, ivch
//   Crossbar in : ird_en, ird_vch
//   Crossbar out: odata, ovalid, ovch, ovc_nempty
//   Credit out  : ocredit_valid, ocredit_vch
//   Status out  : oerr
//   Modports: master = upstream/crossbar side, slave = the buffer itself.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface input_vc_buffer_if #(
  parameter int DATA_WIDTH = input_vc_buffer_pkg::DATA_WIDTH_DEF,
  parameter int VCH_W      = input_vc_buffer_pkg::VCH_WIDTH_NUM
);

  localparam int VC_NUM = 2 ** VCH_W;

  logic [DATA_WIDTH-1:0] idata;
  logic                  ivalid;
  logic [VCH_W-1:0]      ivch;
  logic                  ird_en;
  logic [VCH_W-1:0]      ird_vch;
  logic [DATA_WIDTH-1:0] odata;
  logic                  ovalid;
  logic [VCH_W-1:0]      ovch;
  logic                  ocredit_valid;
  logic [VCH_W-1:0]      ocredit_vch;
  logic [VC_NUM-1:0]     ovc_nempty;
  logic                  oerr;

  modport master (
    output idata, ivalid, ivch, ird_en, ird_vch,
    input  odata, ovalid, ovch, ocredit_valid, ocredit_vch, ovc_nempty, oerr
  );

  modport slave (
    input  idata, ivalid, ivch, ird_en, ird_vch,
    output odata, ovalid, ovch, ocredit_valid, ocredit_vch, ovc_nempty, oerr
  );

endinterface : input_vc_buffer_if

`default_nettype wire

// File: rtl/input_vc_buffer_vc_fifo.sv
// ============================================================================
// Module  : vc_fifo
// Purpose : Single virtual-channel synchronous FIFO. The head entry is
//           presented combinationally on rd_data; the caller registers it.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : push wr_data (ignored when full unless popping this cycle)
//   wr_data  : entry to push
//   rd_en    : pop head (ignored when empty)
//   rd_data  : current head entry
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_fifo #(
  parameter int DATA_WIDTH = input_vc_buffer_pkg::DATA_WIDTH_DEF,
  parameter int DEPTH      = input_vc_buffer_pkg::INBUF_DEPTH,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  output logic      [DATA_WIDTH-1:0] rd_data,
  output logic      [CNT_W-1:0]      count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: nothing is readable until count says so.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : vc_fifo

`default_nettype wire

// File: rtl/input_vc_buffer.sv
// ============================================================================
// Module  : input_vc_buffer
// Purpose : Receive end of a router-to-router link. Stores incoming flits in
//           one FIFO per virtual channel, pops them to the crossbar on
//           request with one cycle latency and returns one credit upstream
//           per popped flit.
//   clk, rst      : clock, synchronous active-high reset
//   bus.idata     : flit from link        bus.ivalid : flit present
//   bus.ivch      : target VC of flit
//   bus.ird_en    : crossbar read request bus.ird_vch: VC to pop
//   bus.odata     : popped flit (reg)     bus.ovalid : odata valid (reg)
//   bus.ovch      : VC of popped flit (reg)
//   bus.ocredit_valid / ocredit_vch : credit pulse and its VC (reg)
//   bus.ovc_nempty: per-VC non-empty flags
//   bus.oerr      : sticky protocol error
// Build option: INBUF_ERR_CHECK_EN enables oerr detection (drop at full,
//   read of an empty VC); without it oerr is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module input_vc_buffer #(
  parameter int DATA_WIDTH = input_vc_buffer_pkg::DATA_WIDTH_DEF,
  parameter int VCH_W      = input_vc_buffer_pkg::VCH_WIDTH_NUM,
  parameter int DEPTH      = input_vc_buffer_pkg::INBUF_DEPTH,
  parameter int CNT_W      = input_vc_buffer_pkg::cnt_width(DEPTH)
) (
  input wire logic         clk,
  input wire logic         rst,
  input_vc_buffer_if.slave bus
);

  import input_vc_buffer_pkg::*;

  localparam int VC_NUM = 2 ** VCH_W;

  logic [VC_NUM-1:0]     wr_sel;
  logic [VC_NUM-1:0]     rd_sel;
  logic [VC_NUM-1:0]     full_v;
  logic [VC_NUM-1:0]     empty_v;
  logic [VC_NUM-1:0]     nempty_v;
  logic [DATA_WIDTH-1:0] head [VC_NUM];
  logic [CNT_W-1:0]      count [VC_NUM];
  logic                  pop_ok;

  logic [DATA_WIDTH-1:0] odata_q;
  logic                  ovalid_q;
  logic [VCH_W-1:0]      ovch_q;
  logic                  credit_valid_q;
  logic [VCH_W-1:0]      credit_vch_q;

  // Write/read demux. A write to a full VC is only let through when that
  // same VC is being popped (full implies non-empty, so the pop is real).
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    nempty_v = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      rd_sel[v]   = bus.ird_en && (bus.ird_vch == VCH_W'(v));
      wr_sel[v]   = bus.ivalid && (bus.ivch == VCH_W'(v)) && (!full_v[v] || rd_sel[v]);
      nempty_v[v] = (count[v] != '0);
    end
  end

  assign pop_ok = bus.ird_en && !empty_v[bus.ird_vch];

  generate
    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
      vc_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_sel[g]),
        .wr_data (bus.idata),
        .rd_en   (rd_sel[g]),
        .rd_data (head[g]),
        .count   (count[g]),
        .full    (full_v[g]),
        .empty   (empty_v[g])
      );
    end
  endgenerate

  // Output and credit registers. odata/ovch hold across non-pop cycles so
  // the crossbar sees a stable bus; only the valid strobes drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata_q        <= '0;
      ovalid_q       <= 1'b0;
      ovch_q         <= '0;
      credit_valid_q <= 1'b0;
      credit_vch_q   <= '0;
    end else begin
      ovalid_q       <= pop_ok;
      credit_valid_q <= pop_ok;
      if (pop_ok) begin
        odata_q      <= head[bus.ird_vch];
        ovch_q       <= bus.ird_vch;
        credit_vch_q <= bus.ird_vch;
      end
    end
  end

  assign bus.odata         = odata_q;
  assign bus.ovalid        = ovalid_q;
  assign bus.ovch          = ovch_q;
  assign bus.ocredit_valid = credit_valid_q;
  assign bus.ocredit_vch   = credit_vch_q;
  assign bus.ovc_nempty    = nempty_v;

`ifdef INBUF_ERR_CHECK_EN
  logic err_q;
  logic wr_drop;
  logic rd_empty;

  // Upstream overran its credits, or the allocator granted an empty VC.
  assign wr_drop  = bus.ivalid && full_v[bus.ivch] && !rd_sel[bus.ivch];
  assign rd_empty = bus.ird_en && empty_v[bus.ird_vch];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_drop || rd_empty) begin
      err_q <= 1'b1;
    end
  end

  assign bus.oerr = err_q;
`else
  assign bus.oerr = 1'b0;
`endif

endmodule : input_vc_buffer

`default_nettype wire

// File: tb/tb_input_vc_buffer.sv
// ============================================================================
// Module  : tb_input_vc_buffer
// Purpose : Directed self-checking bench for input_vc_buffer (DEPTH 4,
//           16-bit flits, 4 VCs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_vc_buffer;

`ifdef INBUF_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   credit_cnt;
  int   exp_pops;

  input_vc_buffer_if #(.DATA_WIDTH(16), .VCH_W(2)) bus ();

  input_vc_buffer #(.DATA_WIDTH(16), .VCH_W(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each credit pulse is exactly one cycle wide, so one sample per cycle.
  always @(negedge clk) begin
    if (rst) credit_cnt = 0;
    else if (bus.ocredit_valid) credit_cnt = credit_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [1:0] wvch, input logic [15:0] wd,
                       input logic re, input logic [1:0] rvch);
    bus.ivalid  = wv;
    bus.ivch    = wvch;
    bus.idata   = wd;
    bus.ird_en  = re;
    bus.ird_vch = rvch;
    tick();
    bus.ivalid  = 1'b0;
    bus.ird_en  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] vch, input logic [15:0] d);
    drive(1'b1, vch, d, 1'b0, 2'd0);
  endtask

  // Pop vch and check the registered result one cycle later.
  task automatic pop_chk(input string tag, input logic [1:0] vch,
                         input logic ev, input logic [15:0] ed);
    drive(1'b0, 2'd0, 16'h0, 1'b1, vch);
    chk({tag, ".ovalid"}, 32'(bus.ovalid), 32'(ev));
    chk({tag, ".credit"}, 32'(bus.ocredit_valid), 32'(ev));
    chk({tag, ".odata"}, 32'(bus.odata), 32'(ed));
    if (ev) begin
      exp_pops = exp_pops + 1;
      chk({tag, ".ovch"}, 32'(bus.ovch), 32'(vch));
      chk({tag, ".cvch"}, 32'(bus.ocredit_vch), 32'(vch));
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    exp_pops   = 0;
    credit_cnt = 0;
    bus.idata   = '0;
    bus.ivalid  = 1'b0;
    bus.ivch    = '0;
    bus.ird_en  = 1'b0;
    bus.ird_vch = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.odata", 32'(bus.odata), 32'h0);
    chk("rst.ovalid", 32'(bus.ovalid), 32'h0);
    chk("rst.ovch", 32'(bus.ovch), 32'h0);
    chk("rst.credit", 32'(bus.ocredit_valid), 32'h0);
    chk("rst.cvch", 32'(bus.ocredit_vch), 32'h0);
    chk("rst.nempty", 32'(bus.ovc_nempty), 32'h0);
    chk("rst.oerr", 32'(bus.oerr), 32'h0);

    // Single flit through VC2
    wr(2'd2, 16'h00A5);
    chk("t1.nempty", 32'(bus.ovc_nempty), 32'b0100);
    chk("t1.ovalid_wr", 32'(bus.ovalid), 32'h0);
    pop_chk("t1.pop", 2'd2, 1'b1, 16'h00A5);
    chk("t1.nempty_after", 32'(bus.ovc_nempty), 32'h0);

    // FIFO order on VC0
    for (int i = 1; i <= 4; i++) wr(2'd0, 16'(i));
    chk("t2.nempty", 32'(bus.ovc_nempty), 32'b0001);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("t2.pop%0d", i), 2'd0, 1'b1, 16'(i));
    chk("t2.nempty_after", 32'(bus.ovc_nempty), 32'h0);
    chk("t2.oerr", 32'(bus.oerr), 32'h0);

    // Overflow of VC1: 5th write dropped
    for (int i = 0; i < 4; i++) wr(2'd1, 16'h0021 + 16'(i));
    chk("t3.nempty", 32'(bus.ovc_nempty), 32'b0010);
    chk("t3.oerr_pre", 32'(bus.oerr), 32'h0);
    wr(2'd1, 16'd10);
    chk("t3.oerr", 32'(bus.oerr), 32'(ERR_EN));
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("t3.pop%0d", i), 2'd1, 1'b1, 16'h0021 + 16'(i));
    pop_chk("t3.pop_empty", 2'd1, 1'b0, 16'h0024);
    chk("t3.nempty_after", 32'(bus.ovc_nempty), 32'h0);

    // VC3 full: simultaneous write and pop
    for (int i = 0; i < 4; i++) wr(2'd3, 16'h0031 + 16'(i));
    drive(1'b1, 2'd3, 16'h0077, 1'b1, 2'd3);
    exp_pops = exp_pops + 1;
    chk("t4.ovalid", 32'(bus.ovalid), 32'h1);
    chk("t4.odata", 32'(bus.odata), 32'h0031);
    chk("t4.nempty", 32'(bus.ovc_nempty), 32'b1000);
    pop_chk("t4.pop0", 2'd3, 1'b1, 16'h0032);
    pop_chk("t4.pop1", 2'd3, 1'b1, 16'h0033);
    pop_chk("t4.pop2", 2'd3, 1'b1, 16'h0034);
    pop_chk("t4.pop3", 2'd3, 1'b1, 16'h0077);
    chk("t4.nempty_after", 32'(bus.ovc_nempty), 32'h0);

    // VC0 empty: write and read same cycle, no bypass
    drive(1'b1, 2'd0, 16'h0011, 1'b1, 2'd0);
    chk("t5.ovalid", 32'(bus.ovalid), 32'h0);
    chk("t5.credit", 32'(bus.ocredit_valid), 32'h0);
    chk("t5.odata_hold", 32'(bus.odata), 32'h0077);
    chk("t5.nempty", 32'(bus.ovc_nempty), 32'b0001);
    pop_chk("t5.pop", 2'd0, 1'b1, 16'h0011);

    // Interleaved: writes alternate VC0/VC1 while VC2 drains
    for (int i = 0; i < 4; i++) wr(2'd2, 16'h0041 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i % 2), 16'h0050 + 16'(i), 1'b1, 2'd2);
      exp_pops = exp_pops + 1;
      chk($sformatf("t6.il%0d.odata", i), 32'(bus.odata), 32'h0041 + 32'(i));
      chk($sformatf("t6.il%0d.cvch", i), 32'(bus.ocredit_vch), 32'd2);
    end
    chk("t6.nempty", 32'(bus.ovc_nempty), 32'b0011);
    pop_chk("t6.vc0a", 2'd0, 1'b1, 16'h0050);
    pop_chk("t6.vc1a", 2'd1, 1'b1, 16'h0051);
    pop_chk("t6.vc0b", 2'd0, 1'b1, 16'h0052);
    tick();
    chk("t6.credits", 32'(credit_cnt), 32'(exp_pops));

    // Reset mid-stream: VC1 still holds 0x53, VC3 gets a flit
    wr(2'd3, 16'h0099);
    bus.ivalid  = 1'b1;
    bus.ivch    = 2'd0;
    bus.idata   = 16'h00EE;
    bus.ird_en  = 1'b1;
    bus.ird_vch = 2'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ivalid = 1'b0;
    bus.ird_en = 1'b0;
    chk("t7.nempty", 32'(bus.ovc_nempty), 32'h0);
    chk("t7.ovalid", 32'(bus.ovalid), 32'h0);
    chk("t7.odata", 32'(bus.odata), 32'h0);
    chk("t7.credit", 32'(bus.ocredit_valid), 32'h0);
    chk("t7.ovch", 32'(bus.ovch), 32'h0);
    chk("t7.oerr", 32'(bus.oerr), 32'h0);
    pop_chk("t7.pop_after", 2'd1, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_input_vc_buffer

`default_nettype wire
